snake_renderer: RTL and testbench

- Downstream consumer of the snake body store. It scans the segment arrays by index and turns them into pixel writes for the 160x120 VGA frame-buffer adapter.
- Each game step runs erase-old-snake, one-cycle move pulse to the body store, then draw-new-snake.
- Sits between the game-step timer/controller and the VGA adapter. It owns the body store's j and move inputs.

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_scan_counter.sv | 33 +++
 rtl/snake_renderer.sv | 111 +++++++++++
 tb/tb_snake_renderer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: screen geometry, colours,
// renderer states and the movement direction encoding.
package snake_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;

  localparam logic [2:0] HEAD_COLOUR = 3'b110;
  localparam logic [2:0] BODY_COLOUR = 3'b010;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_INIT_DRAW,
    ST_IDLE,
    ST_ERASE,
    ST_MOVE,
    ST_SETTLE,
    ST_DRAW,
    ST_DONE
  } rstate_t;

  // Also rejects coordinates that wrapped below zero to 255.
  function automatic logic on_screen(input logic [7:0] x, input logic [7:0] y);
    return (x < SCREEN_W) && (y < SCREEN_H);
  endfunction

endpackage

// File: rtl/snake_scan_counter.sv
// Segment index walker shared by the erase and draw scans: counts up while
// advancing and flags the cycle that ends the scan.
module snake_scan_counter #(
  parameter int MAX_LEN = 100,
  parameter int IDX_W   = 7
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             advance,
  input  logic             seg_valid,
  output logic [IDX_W-1:0] j,
  output logic             last_idx
);

  logic [IDX_W-1:0] j_q, j_d;

  // Ends on the first invalid slot or on the final slot of the array.
  assign last_idx = advance && (!seg_valid || (j_q == IDX_W'(MAX_LEN - 1)));
  assign j        = j_q;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    j_d = '0;
    if (advance && !last_idx) j_d = j_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (!resetn) j_q <= '0;
    else         j_q <= j_d;
  end

endmodule

// File: rtl/snake_renderer.sv
// Turns the snake body store into frame-buffer pixel writes: erase old snake,
// pulse move, then draw the new snake, once per game step.
module snake_renderer
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 100,
  parameter int IDX_W   = 7
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             frame_tick,
  input  logic             endgame,
  input  logic [7:0]       seg_x,
  input  logic [7:0]       seg_y,
  input  logic             seg_valid,
  output logic [IDX_W-1:0] j,
  output logic             move,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             done
);

  rstate_t    state_q, state_d;
  logic       pending_q, pending_d;
  logic       scanning, last_idx;
  logic       plot_q, plot_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;

  snake_scan_counter #(
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_scan (
    .clock     (clock),
    .resetn    (resetn),
    .advance   (scanning),
    .seg_valid (seg_valid),
    .j         (j),
    .last_idx  (last_idx)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= ST_INIT_DRAW;
      pending_q <= 1'b0;
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= BG_COLOUR;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      ST_INIT_DRAW: if (last_idx) state_d = ST_DONE;
      ST_IDLE: begin
        pending_d = 1'b0;
        if (!endgame && (frame_tick || pending_q)) state_d = ST_ERASE;
      end
      ST_ERASE:  if (last_idx) state_d = ST_MOVE;
      ST_MOVE:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_DRAW;
      ST_DRAW:   if (last_idx) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_INIT_DRAW;
    endcase
    // One-deep request buffer for ticks that arrive mid-step.
    if (state_q != ST_IDLE && frame_tick) pending_d = 1'b1;
  end

  always_comb begin
    scanning = (state_q == ST_INIT_DRAW) || (state_q == ST_ERASE) || (state_q == ST_DRAW);
    move     = (state_q == ST_MOVE);
    done     = (state_q == ST_DONE);
    busy     = (state_q != ST_IDLE);
  end

  // Pixel register: the body store answers this cycle, the write lands next cycle.
  always_comb begin
    plot_d   = scanning && seg_valid && on_screen(seg_x, seg_y);
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (plot_d) begin
      x_d = seg_x;
      y_d = seg_y[6:0];
      if (state_q == ST_ERASE) colour_d = BG_COLOUR;
      else if (j == '0)        colour_d = HEAD_COLOUR;
      else                     colour_d = BODY_COLOUR;
    end
  end

  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = colour_q;

endmodule

// File: tb/tb_snake_renderer.sv
// Directed bench for snake_renderer with a 10-segment body store model that
// moves right on each move strobe.
module tb_snake_renderer;

  typedef struct packed {
    int         cyc;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_t;

  logic       clock, resetn, frame_tick, endgame;
  logic [7:0] seg_x, seg_y;
  logic       seg_valid;
  logic [6:0] j;
  logic       move, vga_plot, busy, done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  logic       load_req;
  logic [7:0] load_x;
  logic [7:0] mx [10];

  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  plot_t plots[$];
  int    moves[$];
  int    dones[$];
  logic  busy_seen;
  int    t0, r0;

  snake_renderer dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .endgame    (endgame),
    .seg_x      (seg_x),
    .seg_y      (seg_y),
    .seg_valid  (seg_valid),
    .j          (j),
    .move       (move),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  // Body store model: straight horizontal snake at y=60, head moving right.
  always @(posedge clock) begin
    if (load_req) begin
      for (int i = 0; i < 10; i++) mx[i] <= load_x - 8'(i);
    end else if (move) begin
      for (int i = 1; i < 10; i++) mx[i] <= mx[i-1];
      mx[0] <= mx[0] + 8'd1;
    end
  end

  always_comb begin
    seg_valid = (j < 7'd10);
    seg_y     = 8'd60;
    seg_x     = seg_valid ? mx[j[3:0]] : 8'd0;
  end

  always @(negedge clock) begin
    if (vga_plot) plots.push_back('{cyc, vga_x, vga_y, vga_colour});
    if (move) moves.push_back(cyc);
    if (done) dones.push_back(cyc);
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_log();
    plots.delete();
    moves.delete();
    dones.delete();
    busy_seen = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic load_snake(input logic [7:0] head_x);
    load_req = 1'b1;
    load_x   = head_x;
    step();
    load_req = 1'b0;
  endtask

  task automatic expect_plots(input string tag, input int first, input int cyc0,
                              input logic [7:0] x0, input int n,
                              input logic [2:0] head_c, input logic [2:0] body_c);
    for (int k = 0; k < n; k++) begin
      if (first + k < plots.size()) begin
        check({tag, "_cyc"}, plots[first+k].cyc, cyc0 + k);
        check({tag, "_x"}, plots[first+k].x, x0 - 8'(k));
        check({tag, "_y"}, plots[first+k].y, 7'd60);
        check({tag, "_colour"}, plots[first+k].c, (k == 0) ? head_c : body_c);
      end else begin
        check({tag, "_missing"}, plots.size(), first + n);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; frame_tick = 1'b0; endgame = 1'b0;
    load_req = 1'b1; load_x = 8'd80; busy_seen = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_plot", vga_plot, 0);
    check("rst_move", move, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 1);
    check("rst_j", j, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);

    // Initial draw of the reset snake
    clear_log();
    r0 = cyc;
    resetn = 1'b1; load_req = 1'b0;
    repeat (20) step();
    check("init_nplots", plots.size(), 10);
    expect_plots("init", 0, r0 + 1, 8'd80, 10, 3'b110, 3'b010);
    check("init_ndone", dones.size(), 1);
    if (dones.size() > 0) check("init_done_cyc", dones[0], r0 + 11);
    check("init_nmove", moves.size(), 0);
    check("init_idle_busy", busy, 0);

    // One game step
    clear_log();
    t0 = cyc + 1;
    pulse_tick();
    repeat (30) step();
    check("step_nplots", plots.size(), 20);
    expect_plots("step_erase", 0, t0 + 1, 8'd80, 10, 3'b000, 3'b000);
    expect_plots("step_draw", 10, t0 + 14, 8'd81, 10, 3'b110, 3'b010);
    check("step_nmove", moves.size(), 1);
    if (moves.size() > 0) check("step_move_cyc", moves[0], t0 + 11);
    check("step_ndone", dones.size(), 1);
    if (dones.size() > 0) check("step_done_cyc", dones[0], t0 + 24);

    // Head leaves the screen on the right edge
    load_snake(8'd159);
    clear_log();
    t0 = cyc + 1;
    pulse_tick();
    repeat (30) step();
    check("clip_nplots", plots.size(), 19);
    expect_plots("clip_erase", 0, t0 + 1, 8'd159, 10, 3'b000, 3'b000);
    expect_plots("clip_draw", 10, t0 + 15, 8'd159, 9, 3'b010, 3'b010);
    check("clip_ndone", dones.size(), 1);
    if (dones.size() > 0) check("clip_done_cyc", dones[0], t0 + 24);

    // Two extra ticks mid-step: one is buffered, the other lost
    load_snake(8'd80);
    clear_log();
    t0 = cyc + 1;
    pulse_tick();
    step();
    pulse_tick();
    step();
    pulse_tick();
    repeat (80) step();
    check("pend_ndone", dones.size(), 2);
    if (dones.size() > 1) begin
      check("pend_done0", dones[0], t0 + 24);
      check("pend_done1", dones[1], t0 + 50);
    end
    check("pend_nmove", moves.size(), 2);
    if (moves.size() > 1) check("pend_move1", moves[1], t0 + 37);
    check("pend_nplots", plots.size(), 40);
    expect_plots("pend_draw2", 30, t0 + 40, 8'd82, 10, 3'b110, 3'b010);

    // Game over: ticks ignored and nothing left pending
    endgame = 1'b1;
    step();
    clear_log();
    pulse_tick();
    step();
    pulse_tick();
    step();
    pulse_tick();
    repeat (5) step();
    endgame = 1'b0;
    repeat (10) step();
    check("end_nplots", plots.size(), 0);
    check("end_nmove", moves.size(), 0);
    check("end_busy_seen", busy_seen, 0);

    // Reset pulse in the middle of a draw scan
    load_snake(8'd80);
    t0 = cyc + 1;
    pulse_tick();
    repeat (16) step();
    resetn = 1'b0; load_req = 1'b1; load_x = 8'd80;
    step();
    resetn = 1'b1; load_req = 1'b0;
    check("mid_rst_plot", vga_plot, 0);
    check("mid_rst_move", move, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_j", j, 0);
    clear_log();
    r0 = cyc;
    repeat (20) step();
    check("rinit_nplots", plots.size(), 10);
    expect_plots("rinit", 0, r0 + 1, 8'd80, 10, 3'b110, 3'b010);
    check("rinit_ndone", dones.size(), 1);
    if (dones.size() > 0) check("rinit_done_cyc", dones[0], r0 + 11);
    check("rinit_nmove", moves.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
